// File: rtl/hpf_transient_detector_pkg.sv
// Shared types and helpers for the HPF transient detector slice (package hpf_pkg).
package hpf_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ACTIVE    = 2'd2,
        RELEASING = 2'd3
    } hpf_state_t;

    // Two's-complement negate keeps the most-negative value as 2^(W-1) when read unsigned.
    function automatic logic [DATA_W_DEF-1:0] abs_mag(input logic signed [DATA_W_DEF-1:0] x);
        return x[DATA_W_DEF-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/hpf_transient_detector_run_counter.sv
// Qualification run counter shared between the arming and releasing phases.
module hpf_run_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    // hit means the increment about to happen would reach the limit.
    assign hit = ({1'b0, count} + {{W{1'b0}}, 1'b1}) == {1'b0, limit};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hpf_transient_detector.sv
// Rectifies HPF samples and flags transients with hysteresis and run qualification.
// Optional peak tracking is built only when HPF_PEAK_TRACK_EN is defined.
module hpf_transient_detector
    import hpf_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int HOLD_N    = 3,
    parameter int RELEASE_N = 4,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic              count_clr,
    output logic              event_pulse,
    output logic              active,
    output logic [CNT_W-1:0]  event_count,
    output logic [DATA_W-1:0] peak_mag
);

    hpf_state_t        state_q, state_d;
    logic [DATA_W-1:0] mag;
    logic              run_clr, run_inc, run_hit, enter_evt;
    logic [7:0]        run_limit, run_count;

    assign mag = abs_mag(sample_in);

    hpf_run_counter #(.W(8)) u_run (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   (run_inc),
        .limit (run_limit),
        .count (run_count),
        .hit   (run_hit)
    );

    // One counter serves both phases; the limit follows which side of the event we are on.
    always_comb begin
        state_d   = state_q;
        run_clr   = 1'b0;
        run_inc   = 1'b0;
        enter_evt = 1'b0;
        run_limit = (state_q == IDLE || state_q == ARMING) ? 8'(HOLD_N) : 8'(RELEASE_N);
        if (sample_valid) begin
            case (state_q)
                IDLE, ARMING: begin
                    if (mag >= thr_hi) begin
                        if (run_hit) begin
                            state_d   = ACTIVE;
                            run_clr   = 1'b1;
                            enter_evt = 1'b1;
                        end else begin
                            state_d = ARMING;
                            run_inc = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        run_clr = 1'b1;
                    end
                end
                ACTIVE, RELEASING: begin
                    if (mag < thr_lo) begin
                        if (run_hit) begin
                            state_d = IDLE;
                            run_clr = 1'b1;
                        end else begin
                            state_d = RELEASING;
                            run_inc = 1'b1;
                        end
                    end else begin
                        state_d = ACTIVE;
                        run_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            event_pulse <= 1'b0;
            active      <= 1'b0;
            event_count <= '0;
        end else begin
            state_q     <= state_d;
            event_pulse <= enter_evt;
            active      <= (state_d == ACTIVE) || (state_d == RELEASING);
            if (count_clr) begin
                event_count <= enter_evt ? CNT_W'(1) : '0;
            end else if (enter_evt && (event_count != {CNT_W{1'b1}})) begin
                event_count <= event_count + 1'b1;
            end
        end
    end

`ifdef HPF_PEAK_TRACK_EN
    logic [DATA_W-1:0] peak_q;

    // A new arming run restarts the peak; it then only grows until the next arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (sample_valid) begin
            if (state_q == IDLE) begin
                if (mag >= thr_hi) begin
                    peak_q <= mag;
                end
            end else if (mag > peak_q) begin
                peak_q <= mag;
            end
        end
    end

    assign peak_mag = peak_q;
`else
    assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_hpf_transient_detector.sv
// Randomized and directed bench for hpf_transient_detector with an event-level reference model.
module tb_hpf_transient_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = '0;
    logic [7:0] thr_hi = 8'd40;
    logic [7:0] thr_lo = 8'd20;
    logic       count_clr = 1'b0;
    logic       event_pulse, active;
    logic [15:0] event_count;
    logic [7:0]  peak_mag;
    logic        s_pulse, s_active;
    logic [1:0]  s_count;
    logic [7:0]  s_peak;

    int checks = 0;
    int errors = 0;

    // Reference model: event flag, consecutive-run length, counts and peak.
    logic m_active, m_pulse;
    int   m_run, m_cnt, m_cnt2, m_peak;

    always #5 clk = ~clk;

    hpf_transient_detector #(.DATA_W(8), .HOLD_N(3), .RELEASE_N(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .count_clr(count_clr),
        .event_pulse(event_pulse), .active(active), .event_count(event_count), .peak_mag(peak_mag)
    );

    hpf_transient_detector #(.DATA_W(8), .HOLD_N(3), .RELEASE_N(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .count_clr(count_clr),
        .event_pulse(s_pulse), .active(s_active), .event_count(s_count), .peak_mag(s_peak)
    );

    function automatic int exp_peak();
`ifdef HPF_PEAK_TRACK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input logic v, input int s, input logic clr, input logic r);
        int mag, hi, lo;
        logic was_active;
        int was_run;
        @(negedge clk);
        sample_valid = v;
        sample_in    = s[7:0];
        count_clr    = clr;
        rst          = r;
        @(posedge clk);
        m_pulse = 1'b0;
        if (r) begin
            m_active = 1'b0; m_run = 0; m_cnt = 0; m_cnt2 = 0; m_peak = 0;
        end else begin
            if (v) begin
                mag = (s < 0) ? -s : s;
                hi = int'(thr_hi);
                lo = int'(thr_lo);
                was_active = m_active;
                was_run = m_run;
                if (!was_active && was_run == 0) begin
                    if (mag >= hi) m_peak = mag;
                end else if (mag > m_peak) begin
                    m_peak = mag;
                end
                if (!was_active) begin
                    if (mag >= hi) begin
                        m_run++;
                        if (m_run >= 3) begin m_active = 1'b1; m_run = 0; m_pulse = 1'b1; end
                    end else m_run = 0;
                end else begin
                    if (mag < lo) begin
                        m_run++;
                        if (m_run >= 4) begin m_active = 1'b0; m_run = 0; end
                    end else m_run = 0;
                end
            end
            if (clr) begin
                m_cnt = m_pulse ? 1 : 0;
                m_cnt2 = m_cnt;
            end else if (m_pulse) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int smp[3] = '{10, -15, 39};
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if ({event_pulse, active, event_count, peak_mag} !== 26'd0) begin
            errors++; $display("[TB] FAIL reset_outputs got %0b/%0b/%0d/%0d want all 0", event_pulse, active, event_count, peak_mag);
        end
        thr_hi = 8'd40; thr_lo = 8'd20;
        foreach (smp[i]) begin
            drive(1'b1, smp[i], 1'b0, 1'b0);
            checks++;
            if (event_pulse !== 1'b0 || active !== 1'b0 || event_count !== 16'd0) begin
                errors++; $display("[TB] FAIL idle_quiet sample %0d got pulse %0b active %0b count %0d want 0/0/0", smp[i], event_pulse, active, event_count);
            end
        end
    endtask

    task automatic test_arm_event();
        int smp[3] = '{50, -60, 45};
        foreach (smp[i]) begin
            drive(1'b1, smp[i], 1'b0, 1'b0);
            checks++;
            if (event_pulse !== (i == 2) || active !== (i == 2)) begin
                errors++; $display("[TB] FAIL arm_timing idx %0d got pulse %0b active %0b want %0b", i, event_pulse, active, i == 2);
            end
        end
        checks++;
        if (event_count !== 16'd1 || int'(peak_mag) !== exp_peak()) begin
            errors++; $display("[TB] FAIL arm_count_peak got %0d/%0d want 1/%0d", event_count, peak_mag, exp_peak());
        end
        drive(1'b1, 100, 1'b0, 1'b0);
        checks++;
        if (event_pulse !== 1'b0 || active !== 1'b1) begin
            errors++; $display("[TB] FAIL pulse_width got pulse %0b active %0b want 0/1", event_pulse, active);
        end
    endtask

    task automatic test_release();
        int smp[7] = '{19, 18, 25, 10, 5, 0, -3};
        foreach (smp[i]) begin
            drive(1'b1, smp[i], 1'b0, 1'b0);
            checks++;
            if (active !== (i != 6) || event_pulse !== 1'b0 || event_count !== 16'd1) begin
                errors++; $display("[TB] FAIL release idx %0d got active %0b pulse %0b count %0d want %0b/0/1", i, active, event_pulse, event_count, i != 6);
            end
        end
        checks++;
        if (int'(peak_mag) !== exp_peak()) begin
            errors++; $display("[TB] FAIL release_peak got %0d want %0d", peak_mag, exp_peak());
        end
    endtask

    task automatic test_broken_arming();
        int smp[5] = '{50, -60, 30, 50, 10};
        foreach (smp[i]) begin
            drive(1'b1, smp[i], 1'b0, 1'b0);
            checks++;
            if (event_pulse !== 1'b0 || active !== 1'b0 || int'(peak_mag) !== exp_peak()) begin
                errors++; $display("[TB] FAIL broken_arm idx %0d got pulse %0b active %0b peak %0d want 0/0/%0d", i, event_pulse, active, peak_mag, exp_peak());
            end
        end
    endtask

    task automatic test_edge_gaps();
        thr_hi = 8'd128; thr_lo = 8'd20;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, (k < 3) ? -128 : 0, 1'b0, 1'b0);
            checks++;
            if (event_pulse !== m_pulse || active !== m_active || int'(peak_mag) !== exp_peak()) begin
                errors++; $display("[TB] FAIL edge_sample %0d got pulse %0b active %0b peak %0d want %0b/%0b/%0d", k, event_pulse, active, peak_mag, m_pulse, m_active, exp_peak());
            end
            for (int g = 0; g < 5; g++) begin
                drive(1'b0, -128, 1'b0, 1'b0);
                checks++;
                if (event_pulse !== 1'b0 || active !== m_active) begin
                    errors++; $display("[TB] FAIL gap_hold k %0d got pulse %0b active %0b want 0/%0b", k, event_pulse, active, m_active);
                end
            end
        end
        checks++;
        if (event_count !== 16'd2 || active !== 1'b0) begin
            errors++; $display("[TB] FAIL edge_final got count %0d active %0b want 2/0", event_count, active);
        end
    endtask

    task automatic test_counter();
        thr_hi = 8'd40; thr_lo = 8'd20;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 7; k++) drive(1'b1, (k < 3) ? 100 : 0, 1'b0, 1'b0);
            checks++;
            if (int'(event_count) !== m_cnt || int'(s_count) !== m_cnt2) begin
                errors++; $display("[TB] FAIL counter_sat event %0d got %0d/%0d want %0d/%0d", e, event_count, s_count, m_cnt, m_cnt2);
            end
        end
        checks++;
        if (s_count !== 2'd3) begin
            errors++; $display("[TB] FAIL counter_sat_final got %0d want 3", s_count);
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (event_count !== 16'd0 || s_count !== 2'd0) begin
            errors++; $display("[TB] FAIL count_clr got %0d/%0d want 0/0", event_count, s_count);
        end
        drive(1'b1, 90, 1'b0, 1'b0);
        drive(1'b1, 90, 1'b0, 1'b0);
        drive(1'b1, 90, 1'b1, 1'b0);
        checks++;
        if (event_pulse !== 1'b1 || event_count !== 16'd1 || s_count !== 2'd1) begin
            errors++; $display("[TB] FAIL clr_on_event got pulse %0b count %0d/%0d want 1/1/1", event_pulse, event_count, s_count);
        end
        drive(1'b1, 90, 1'b0, 1'b0);
        drive(1'b1, 90, 1'b0, 1'b1);
        checks++;
        if ({event_pulse, active, event_count, peak_mag} !== 26'd0 || s_count !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_mid_active got %0b/%0b/%0d/%0d want all 0", event_pulse, active, event_count, peak_mag);
        end
        drive(1'b1, 90, 1'b0, 1'b0);
        drive(1'b1, 90, 1'b0, 1'b0);
        drive(1'b1, 90, 1'b0, 1'b1);
        checks++;
        if (event_pulse !== 1'b0 || active !== 1'b0 || event_count !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_on_entry got pulse %0b active %0b count %0d want 0/0/0", event_pulse, active, event_count);
        end
    endtask

    task automatic test_random();
        logic v, c;
        int s;
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) begin
                thr_hi = 8'($urandom_range(20, 120));
                thr_lo = 8'($urandom_range(0, 130));
            end
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            s = int'($urandom_range(0, 255)) - 128;
            drive(v, s, c, 1'b0);
            checks++;
            if (event_pulse !== m_pulse || active !== m_active || int'(event_count) !== m_cnt ||
                int'(s_count) !== m_cnt2 || int'(peak_mag) !== exp_peak()) begin
                errors++;
                $display("[TB] FAIL random n %0d got p%0b a%0b c%0d s%0d k%0d want p%0b a%0b c%0d s%0d k%0d",
                         n, event_pulse, active, event_count, s_count, peak_mag,
                         m_pulse, m_active, m_cnt, m_cnt2, exp_peak());
            end
        end
    endtask

    initial begin
        m_active = 1'b0; m_pulse = 1'b0; m_run = 0; m_cnt = 0; m_cnt2 = 0; m_peak = 0;
        test_reset();
        test_arm_event();
        test_release();
        test_broken_arming();
        test_edge_gaps();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
